// File: rtl/mpadd_pkg.sv
// rtl/mpadd_pkg.sv - shared constants and types for the multi-precision add/sub sequencer
//
// Contents:
//   WORD_W   width of one adder word
//   state_t  sequencer states (IDLE, RUN, DONE)

package mpadd_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fastcarry_32.sv
// rtl/fastcarry_32.sv - 32-bit carry-lookahead adder, purely combinational
//
// Ports:
//   a, b   input  [31:0]  addends
//   cin    input          carry in
//   s      output [31:0]  sum
//   cout   output         carry out of bit 31
//
// Carries are resolved with full lookahead inside each 4-bit group; group
// generate/propagate terms then pass the carry from group to group.

module fastcarry_32
  import mpadd_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] c;
  logic              ci;
  logic              gg;
  logic              pg;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c  = '0;
    ci = cin;
    gg = 1'b0;
    pg = 1'b0;
    for (int k = 0; k < WORD_W / 4; k++) begin
      c[4*k]   = ci;
      c[4*k+1] = g[4*k] | (p[4*k] & ci);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & ci);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & ci);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = &p[4*k +: 4];
      ci = gg | (pg & ci);
    end
    s    = p ^ c;
    cout = ci;
  end

endmodule

// File: rtl/mpadd_ctrl.sv
// rtl/mpadd_ctrl.sv - word-serial multi-precision add/subtract sequencer
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake; a, b, op_sub captured on accept
//   op_sub              0 = a+b, 1 = a-b
//   a, b                WORDS x 32-bit operands, word 0 in bits [31:0]
//   out_valid,out_ready result handshake; sum/cout/ovf held while out_valid
//   sum                 WORDS x 32-bit result
//   cout                carry out of top word (subtract: 1 = no borrow)
//   ovf                 signed overflow of the full-width result
//
// One word is pushed through the shared adder per RUN cycle, LSW first.
// Subtraction is a + ~b + 1: the "+1" enters as the initial carry.

module mpadd_ctrl
  import mpadd_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [WORD_W*WORDS-1:0] a_q;
  logic [WORD_W*WORDS-1:0] b_q;
  logic [WORD_W*WORDS-1:0] sum_q;
  logic                    sub_q;
  logic                    carry_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    cout_q;
  logic                    ovf_q;

  logic [WORD_W-1:0]       add_a;
  logic [WORD_W-1:0]       add_b;
  logic [WORD_W-1:0]       add_s;
  logic                    add_co;
  logic                    last_word;

  assign add_a     = a_q[idx_q*WORD_W +: WORD_W];
  assign add_b     = b_q[idx_q*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
  assign last_word = (idx_q == IDX_LAST);

  fastcarry_32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_word) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= op_sub;
            carry_q <= op_sub;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*WORD_W +: WORD_W] <= add_s;
          carry_q <= add_co;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_word) begin
            cout_q <= add_co;
            // a^b'^s at bit 31 recovers the carry into the sign bit
            ovf_q  <= add_a[WORD_W-1] ^ add_b[WORD_W-1] ^ add_s[WORD_W-1] ^ add_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mpadd_ctrl.sv
// tb/tb_mpadd_ctrl.sv - scoreboard bench for mpadd_ctrl with directed vectors

module tb_mpadd_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  mpadd_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got sum %h with empty scoreboard", sum);
      end else begin
        mon_e = sb.pop_front();
        check("result_sum", sum, mon_e.sum);
        check("result_cout", W'(cout), W'(mon_e.cout));
        check("result_ovf", W'(ovf), W'(mon_e.ovf));
      end
    end
  end

  // Called just after a rising edge; returns the cycle in which the handshake happened.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                      input logic [W-1:0] es, input logic ec, input logic eo, output int t_hs);
    exp_t e;
    a        = ta;
    b        = tb;
    op_sub   = ts;
    in_valid = 1'b1;
    t_hs     = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t_hs   = cyc;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got in_ready low for 50 cycles, required high");
  endtask

  // Returns at the falling edge where out_valid is first seen.
  task automatic wait_out(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        t = cyc;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL out_timeout: got out_valid low for 40 cycles, required high");
  endtask

  localparam logic [W-1:0] ONES   = {W{1'b1}};
  localparam logic [W-1:0] SMAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] X_A    = 128'h00000001_00000002_00000003_00000004;
  localparam logic [W-1:0] X_B    = 128'h10000000_20000000_30000000_40000000;
  localparam logic [W-1:0] X_S    = 128'h10000001_20000002_30000003_40000004;
  localparam logic [W-1:0] Y_A    = 128'h00000000_00000000_00000001_00000000;
  localparam logic [W-1:0] Y_S    = 128'h00000000_00000000_00000000_FFFFFFFF;
  localparam logic [W-1:0] C_A    = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [W-1:0] C_S    = 128'h00000000_00000001_00000000_00000000;

  initial begin
    int t_hs;
    int t_out;
    int t_u;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;

    #12;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_sum", sum, '0);
    check("reset_cout", W'(cout), W'(0));
    check("reset_ovf", W'(ovf), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all ones + 1, with latency measurement
    send(ONES, ONE, 1'b0, '0, 1'b1, 1'b0, t_hs);
    wait_out(t_out);
    check("latency", W'(t_out - t_hs), W'(WORDS + 1));
    @(posedge clk);
    #1;

    // 0 - 1
    send('0, ONE, 1'b1, ONES, 1'b0, 1'b0, t_hs);
    wait_out(t_out);
    @(posedge clk);
    #1;

    // signed overflow on add
    send(SMAX, ONE, 1'b0, SMIN, 1'b0, 1'b1, t_hs);
    wait_out(t_out);
    @(posedge clk);
    #1;

    // signed overflow on subtract
    send(SMIN, ONE, 1'b1, SMAX, 1'b1, 1'b1, t_hs);
    wait_out(t_out);
    @(posedge clk);
    #1;

    // carry ripples across two word boundaries
    send(C_A, ONE, 1'b0, C_S, 1'b0, 1'b0, t_hs);
    wait_out(t_out);
    @(posedge clk);
    #1;

    // backpressure with new operands pending on the input
    out_ready = 1'b0;
    send(X_A, X_B, 1'b0, X_S, 1'b0, 1'b0, t_hs);
    wait_out(t_out);
    @(posedge clk);
    #1;
    a        = Y_A;
    b        = ONE;
    op_sub   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sum", sum, X_S);
      check("bp_cout", W'(cout), W'(0));
      check("bp_ovf", W'(ovf), W'(0));
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_out_valid", W'(out_valid), W'(1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    t_u = cyc;
    @(posedge clk);
    #1;
    send(Y_A, ONE, 1'b1, Y_S, 1'b1, 1'b0, t_hs);
    check("bp_accept_cycle", W'(t_hs - t_u), W'(1));
    wait_out(t_out);
    @(posedge clk);
    #1;

    // reset during the second RUN cycle
    send(ONES, '0, 1'b0, ONES, 1'b0, 1'b0, t_hs);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    send(W'(5), W'(7), 1'b0, W'(12), 1'b0, 1'b0, t_hs);
    wait_out(t_out);
    check("post_rst_latency", W'(t_out - t_hs), W'(WORDS + 1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
